gamma_lut_interp: RTL
=====================

Name: gamma_lut_interp

Overview:
- Multi-channel gamma correction stage on the camera pixel path, placed after demosaic and ahead of the display and VGA path.
- Each channel maps its pixel through a programmable piecewise-linear curve. The curve is a coarse knot table plus linear interpolation.
- Knot tables are double-buffered. The host fills the inactive bank, and bank swaps happen only at start-of-frame, so a frame never tears.
- Fixed 3-cycle pipeline with the valid flag aligned to the data.

Parameters:
- DATA_WIDTH, 10, pixel bits per channel.
- NCH, 3, number of channels.
- LUT_ABITS, 4, log2 of the segment count. There are 2^LUT_ABITS+1 knots per channel per bank. Must be less than DATA_WIDTH.
- FRAC_BITS (localparam), DATA_WIDTH-LUT_ABITS, interpolation fraction bits.
- CH_BITS (localparam), max(1, clog2(NCH)), channel select width.

Ports:
- iCLK  in  1  pixel and host clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDVAL  in  1  input pixel valid.
- iSOF  in  1  start-of-frame pulse; coincides with the first pixel of the frame.
- iDATA  in  NCH*DATA_WIDTH  pixels; channel c is at [c*DATA_WIDTH +: DATA_WIDTH].
- oDVAL  out  1  output valid, iDVAL delayed 3 cycles.
- oDATA  out  NCH*DATA_WIDTH  corrected pixels, same packing as iDATA.
- iWR_EN  in  1  host knot write strobe.
- iWR_CH  in  CH_BITS  target channel.
- iWR_ADDR  in  LUT_ABITS+1  knot index.
- iWR_DATA  in  DATA_WIDTH  knot value.
- iSWAP  in  1  request a bank swap at the next iSOF.
- oSWAP_PENDING  out  1  a swap is armed and not yet applied.
- oSWAP_DONE  out  1  one-cycle pulse when a swap is applied.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Both banks load identity: knot k = k<<FRAC_BITS, saturated to 2^DATA_WIDTH-1 (the last knot saturates).
  - Active bank = 0.
  - Pending = 0.
  - oDVAL, oDATA, oSWAP_DONE = 0; all pipeline registers = 0.
- Knot storage: a register array per bank and channel, so two knots can be read in the same cycle.
- Host write: when iWR_EN=1, knot [inactive bank][iWR_CH][iWR_ADDR] <= iWR_DATA at that edge.
  - Ignored if iWR_CH >= NCH or iWR_ADDR > 2^LUT_ABITS.
  - Writes never touch the active bank.
- Swap state machine, states IDLE and ARMED:
  - IDLE: iSWAP and not iSOF → ARMED.
  - iSWAP together with iSOF, from either state → swap at that edge, pulse oSWAP_DONE, go to IDLE.
  - ARMED: iSOF → active bank toggles, oSWAP_DONE pulses next cycle, go to IDLE.
  - ARMED: further iSWAP has no effect.
  - oSWAP_PENDING = 1 in ARMED.
- Bank for a pixel: the pixel sampled with an iSOF that applies a swap already uses the new bank.
  - Effective bank = active XOR (iSOF AND (ARMED OR iSWAP)).
- A host write in the same cycle as a swap targets the pre-swap inactive bank, i.e. the newly active bank. This is legal; software must avoid it.
- Pipeline, identical for every channel:
  - S1: register idx = x[DATA_WIDTH-1:FRAC_BITS], frac = x[FRAC_BITS-1:0], bank, DVAL.
  - S2: register y0 = knot[idx] and y1 = knot[idx+1] from the registered bank, plus frac and DVAL.
  - S3: d = y1-y0, signed, DATA_WIDTH+1 bits.
    - r = (d*frac + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift.
    - out = clamp(y0 + r, 0, 2^DATA_WIDTH-1).
    - Register into oDATA; oDVAL <= S2 DVAL.
- Latency: exactly 3 iCLK cycles from an input edge to oDATA/oDVAL.
- Non-valid pixels still flow through the datapath; oDATA when oDVAL=0 is don't-care but deterministic.
- No back-pressure: one pixel per clock is always accepted.

Optional Feature:
- Macro GAMMA_BYPASS_EN.
- Defined: adds input port iBYPASS (1 bit). It is sampled in S1 and carried down the pipe. When the carried bit is 1, the S3 output is the S1-registered raw pixel, so latency stays 3 cycles and the bypass is per pixel and glitch-free.
- Undefined: no port and no bypass logic; the behaviour is exactly as above.

Test Plan:
- Reset, no writes, DATA_WIDTH=10, LUT_ABITS=4 → input 500 gives 500 three cycles later; input 1023 gives 1022; input 0 gives 0; oDVAL equals iDVAL delayed by 3.
- Write ch0 knot3=300 and knot4=400, pulse iSWAP, then iSOF with pixel 224 → output 350 three cycles later; oSWAP_DONE pulses once; oSWAP_PENDING falls.
- Write ch1 knot3=400 and knot4=300, swap, then pixel 193 → 398 (negative slope, rounding checked).
- Writes plus iSWAP with no iSOF → outputs stay identity and oSWAP_PENDING=1. The next iSOF pixel is the first one that uses the new table.
- iWR_CH=3 with NCH=3, and iWR_ADDR=17 → no knot changes; assert iRST_N low mid-frame → oDVAL=0 immediately and tables return to identity.
- With GAMMA_BYPASS_EN and a loaded gamma table, toggle iBYPASS every pixel → outputs alternate between raw and corrected values with 3-cycle latency.

Source files
------------

// File: rtl/gamma_lut_interp.sv
// gamma_lut_interp: per-channel piecewise-linear gamma curve (knot table + linear interpolation).
// Latency: fixed 3 iCLK cycles from iDATA/iDVAL to oDATA/oDVAL, valid aligned with data.
// Backpressure: none; one pixel per clock is always accepted.
//
// Ports:
//   iCLK, iRST_N                 clock, async active-low reset
//   iDVAL, iSOF, iDATA           pixel valid, start-of-frame, packed pixels (channel c at [c*DATA_WIDTH +: DATA_WIDTH])
//   oDVAL, oDATA                 corrected pixels, same packing
//   iWR_EN/CH/ADDR/DATA          host knot write into the inactive bank
//   iSWAP                        request bank swap at next iSOF
//   oSWAP_PENDING, oSWAP_DONE    swap armed / one-cycle pulse when applied
// Optional: GAMMA_BYPASS_EN adds iBYPASS, a per-pixel bypass carried down the pipe.
module gamma_lut_interp #(
  parameter  int DATA_WIDTH = 10,
  parameter  int NCH        = 3,
  parameter  int LUT_ABITS  = 4,
  localparam int FRAC_BITS  = DATA_WIDTH - LUT_ABITS,
  localparam int CH_BITS    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic                      iDVAL,
  input  logic                      iSOF,
  input  logic [NCH*DATA_WIDTH-1:0] iDATA,
`ifdef GAMMA_BYPASS_EN
  input  logic                      iBYPASS,
`endif
  output logic                      oDVAL,
  output logic [NCH*DATA_WIDTH-1:0] oDATA,
  input  logic                      iWR_EN,
  input  logic [CH_BITS-1:0]        iWR_CH,
  input  logic [LUT_ABITS:0]        iWR_ADDR,
  input  logic [DATA_WIDTH-1:0]     iWR_DATA,
  input  logic                      iSWAP,
  output logic                      oSWAP_PENDING,
  output logic                      oSWAP_DONE
);

  localparam int NKNOT = (1 << LUT_ABITS) + 1;
  localparam int IW    = LUT_ABITS + 1;
  localparam int PW    = DATA_WIDTH + FRAC_BITS + 2;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** DATA_WIDTH - 1);

  // Identity knot; the last knot would be 2^DATA_WIDTH and saturates.
  function automatic logic [DATA_WIDTH-1:0] ident(input int k);
    if (k >= (1 << LUT_ABITS)) ident = '1;
    else                       ident = DATA_WIDTH'(k << FRAC_BITS);
  endfunction

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} swap_state_t;

  swap_state_t           state;
  logic                  act_bank;
  logic                  swap_now;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] knot [0:1][0:NCH-1][0:NKNOT-1];

  // Swap applies at an iSOF edge if armed or requested in the same cycle.
  assign swap_now      = iSOF & ((state == ARMED) | iSWAP);
  assign oSWAP_PENDING = (state == ARMED);
  assign wr_ok         = iWR_EN && (32'(iWR_CH) < NCH) && (32'(iWR_ADDR) < NKNOT);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      act_bank   <= 1'b0;
      oSWAP_DONE <= 1'b0;
    end else begin
      oSWAP_DONE <= swap_now;
      if (swap_now) begin
        act_bank <= ~act_bank;
        state    <= IDLE;
      end else if (iSWAP) begin
        state    <= ARMED;
      end
    end
  end

  // Writes use the pre-edge inactive bank, so a write coinciding with a swap
  // lands in the bank that becomes active at that same edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < NKNOT; k++)
            knot[b][c][k] <= ident(k);
    end else if (wr_ok) begin
      knot[~act_bank][iWR_CH][iWR_ADDR] <= iWR_DATA;
    end
  end

  // ---------------- S1: sample pixel, bank, valid ----------------
  logic [NCH*DATA_WIDTH-1:0] s1_pix;
  logic                      s1_bank;
  logic                      s1_dval;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_pix  <= '0;
      s1_bank <= 1'b0;
      s1_dval <= 1'b0;
    end else begin
      s1_pix  <= iDATA;
      s1_bank <= act_bank ^ swap_now;
      s1_dval <= iDVAL;
    end
  end

  // ---------------- S2: fetch the two bracketing knots ----------------
  logic [IW-1:0]         s1_idx [NCH];
  logic [DATA_WIDTH-1:0] y0_n   [NCH];
  logic [DATA_WIDTH-1:0] y1_n   [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      s1_idx[c] = IW'(s1_pix[c*DATA_WIDTH+FRAC_BITS +: LUT_ABITS]);
      y0_n[c]   = knot[s1_bank][c][s1_idx[c]];
      y1_n[c]   = knot[s1_bank][c][s1_idx[c] + IW'(1)];
    end
  end

  logic [DATA_WIDTH-1:0] s2_y0   [NCH];
  logic [DATA_WIDTH-1:0] s2_y1   [NCH];
  logic [FRAC_BITS-1:0]  s2_frac [NCH];
  logic                  s2_dval;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int c = 0; c < NCH; c++) begin
        s2_y0[c]   <= '0;
        s2_y1[c]   <= '0;
        s2_frac[c] <= '0;
      end
      s2_dval <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        s2_y0[c]   <= y0_n[c];
        s2_y1[c]   <= y1_n[c];
        s2_frac[c] <= s1_pix[c*DATA_WIDTH +: FRAC_BITS];
      end
      s2_dval <= s1_dval;
    end
  end

`ifdef GAMMA_BYPASS_EN
  // Bypass flag and raw pixel ride alongside the datapath so the switch is per pixel.
  logic                      s1_byp;
  logic                      s2_byp;
  logic [NCH*DATA_WIDTH-1:0] s2_raw;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_byp <= 1'b0;
      s2_byp <= 1'b0;
      s2_raw <= '0;
    end else begin
      s1_byp <= iBYPASS;
      s2_byp <= s1_byp;
      s2_raw <= s1_pix;
    end
  end
`endif

  // ---------------- S3: interpolate, round, clamp ----------------
  // r = (d*frac + half) >>> FRAC_BITS rounds toward +inf at .5, also for negative slopes.
  logic [DATA_WIDTH-1:0] res [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      logic signed [DATA_WIDTH:0] d;
      logic signed [PW-1:0]       prod;
      logic signed [PW-1:0]       sum;
      d    = $signed({1'b0, s2_y1[c]}) - $signed({1'b0, s2_y0[c]});
      prod = PW'(d) * $signed(PW'({1'b0, s2_frac[c]}));
      sum  = ((prod + HALF) >>> FRAC_BITS) + $signed(PW'({1'b0, s2_y0[c]}));
      if (sum < 0)         res[c] = '0;
      else if (sum > MAXV) res[c] = '1;
      else                 res[c] = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= s2_dval;
      for (int c = 0; c < NCH; c++) begin
`ifdef GAMMA_BYPASS_EN
        oDATA[c*DATA_WIDTH +: DATA_WIDTH] <= s2_byp ? s2_raw[c*DATA_WIDTH +: DATA_WIDTH] : res[c];
`else
        oDATA[c*DATA_WIDTH +: DATA_WIDTH] <= res[c];
`endif
      end
    end
  end

endmodule
